// File: rtl/bcd_convert_ctrl_pkg.sv
// rtl/bcd_convert_ctrl_pkg.sv - shared widths, iteration count and FSM state type
package bcd_convert_ctrl_pkg;

    localparam int BIN_W      = 6;
    localparam int DIGIT_W    = 4;
    localparam int ITER_COUNT = 6;
    localparam int WORK_W     = BIN_W + 2 * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// rtl/bcd_convert_ctrl_if.sv - request/result bundle of the binary-to-BCD converter
interface bcd_convert_ctrl_if;
    import bcd_convert_ctrl_pkg::*;

    logic               start;
    logic [BIN_W-1:0]   bin_in;
    logic               ready;
    logic               busy;
    logic               done;
    logic [DIGIT_W-1:0] bcd_tens;
    logic [DIGIT_W-1:0] bcd_ones;
    logic               neg;

    modport master (
        output start, bin_in,
        input  ready, busy, done, bcd_tens, bcd_ones, neg
    );

    modport slave (
        input  start, bin_in,
        output ready, busy, done, bcd_tens, bcd_ones, neg
    );

endinterface

// File: rtl/bcd_convert_ctrl_bcd_add3.sv
// rtl/bcd_convert_ctrl_bcd_add3.sv - add-3-if-at-least-5 digit correction cell
module bcd_add3
    import bcd_convert_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // a digit of 5 or more would overflow 9 after doubling, so pre-bias it by 3
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(5)) begin
            digit_out = digit_in + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_convert_ctrl.sv
// rtl/bcd_convert_ctrl.sv - 6-bit binary to two-digit BCD converter, optional signed input via BCD_CONV_SIGNED_EN
module bcd_convert_ctrl
    import bcd_convert_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    bcd_convert_ctrl_if.slave  bus
);

    state_t             state;
    state_t             state_next;
    logic [WORK_W-1:0]  work;
    logic [WORK_W-1:0]  work_shifted;
    logic [2:0]         iter_cnt;
    logic [DIGIT_W-1:0] tens_adj;
    logic [DIGIT_W-1:0] ones_adj;
    logic [BIN_W-1:0]   operand;
    logic               operand_neg;
    logic               neg_lat;
    logic               accept;
    logic               last_shift;
    logic [DIGIT_W-1:0] tens_q;
    logic [DIGIT_W-1:0] ones_q;
    logic               neg_q;

`ifdef BCD_CONV_SIGNED_EN
    // two's complement input: convert the magnitude, remember the sign; -32 negates to 6'b100000 = 32
    assign operand_neg = bus.bin_in[BIN_W-1];
    assign operand     = operand_neg ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
`else
    assign operand_neg = 1'b0;
    assign operand     = bus.bin_in;
`endif

    assign accept     = (state == IDLE) && bus.start;
    assign last_shift = (iter_cnt == 3'(ITER_COUNT - 1));

    bcd_add3 u_add3_tens (
        .digit_in  (work[WORK_W-1 -: DIGIT_W]),
        .digit_out (tens_adj)
    );

    bcd_add3 u_add3_ones (
        .digit_in  (work[BIN_W +: DIGIT_W]),
        .digit_out (ones_adj)
    );

    // one double-dabble step: corrected digits, then the whole register moves left by one
    assign work_shifted = {tens_adj, ones_adj, work[BIN_W-1:0]} << 1;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // working register, iteration counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            iter_cnt <= '0;
            neg_lat  <= 1'b0;
            tens_q   <= '0;
            ones_q   <= '0;
            neg_q    <= 1'b0;
        end else if (accept) begin
            work     <= {{(2 * DIGIT_W){1'b0}}, operand};
            iter_cnt <= '0;
            neg_lat  <= operand_neg;
        end else if (state == SHIFT) begin
            work     <= work_shifted;
            iter_cnt <= iter_cnt + 3'd1;
            // results only change when a conversion completes, never mid-way
            if (last_shift) begin
                tens_q <= work_shifted[WORK_W-1 -: DIGIT_W];
                ones_q <= work_shifted[BIN_W +: DIGIT_W];
                neg_q  <= neg_lat;
            end
        end
    end

    assign bus.bcd_tens = tens_q;
    assign bus.bcd_ones = ones_q;
    assign bus.neg      = neg_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// tb/tb_bcd_convert_ctrl.sv - randomized and directed checks of bcd_convert_ctrl against a behavioural model
module tb_bcd_convert_ctrl;
    import bcd_convert_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    bcd_convert_ctrl_if bus ();

    bcd_convert_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference conversion: {neg, tens, ones} from plain arithmetic
    function automatic logic [8:0] ref_conv(input logic [5:0] b);
        int   mag;
        logic n;
`ifdef BCD_CONV_SIGNED_EN
        n   = b[5];
        mag = n ? (64 - int'(b)) : int'(b);
`else
        n   = 1'b0;
        mag = int'(b);
`endif
        return {n, 4'(mag / 10), 4'(mag % 10)};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // timing/result model: phase 0 idle, 1..6 converting, 7 done pulse
    int         phase = 0;
    logic [8:0] m_res = '0;
    logic [8:0] m_pend = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            phase = 0;
            m_res = '0;
            chk("rst_ready", bus.ready, 1);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_result", {bus.neg, bus.bcd_tens, bus.bcd_ones}, 0);
        end else begin
            chk("ready", bus.ready, (phase == 0));
            chk("busy", bus.busy, (phase >= 1 && phase <= 6));
            chk("done", bus.done, (phase == 7));
            chk("result", {bus.neg, bus.bcd_tens, bus.bcd_ones}, m_res);
            if (phase == 0) begin
                if (bus.start === 1'b1) begin
                    m_pend = ref_conv(bus.bin_in);
                    phase  = 1;
                end
            end else if (phase < 6) begin
                phase++;
            end else if (phase == 6) begin
                phase = 7;
                m_res = m_pend;
            end else begin
                phase = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (bus.ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("ready_timeout", 0, 1);
    endtask

    task automatic convert(input logic [5:0] v, output logic [8:0] res, output int lat);
        wait_ready();
        bus.start  = 1'b1;
        bus.bin_in = v;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        res = {bus.neg, bus.bcd_tens, bus.bcd_ones};
        tick();
    endtask

    logic [5:0] dir_in  [5];
    logic [8:0] dir_exp [5];

    initial begin
        logic [8:0] res;
        int         lat;
        int         t;
        int         last_done;
        int         done_seen;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef BCD_CONV_SIGNED_EN
        dir_in  = '{6'b100000, 6'b111111, 6'd31, 6'd0, 6'd10};
        dir_exp = '{9'h132, 9'h101, 9'h031, 9'h000, 9'h010};
        chk("model_42", ref_conv(6'd42), 9'h122);
`else
        dir_in  = '{6'd63, 6'd0, 6'd9, 6'd10, 6'd42};
        dir_exp = '{9'h063, 9'h000, 9'h009, 9'h010, 9'h042};
        chk("model_42", ref_conv(6'd42), 9'h042);
`endif
        chk("model_10", ref_conv(6'd10), 9'h010);

        for (int i = 0; i < 5; i++) begin
            convert(dir_in[i], res, lat);
            chk($sformatf("directed_%0d", dir_in[i]), res, dir_exp[i]);
            chk($sformatf("latency_%0d", dir_in[i]), lat, 6);
        end

        for (int v = 0; v < 64; v++) begin
            convert(6'(v), res, lat);
            chk($sformatf("exhaustive_%0d", v), res, ref_conv(6'(v)));
        end

        // start held high: back-to-back conversions every 8 cycles, bin_in wiggled while busy
        wait_ready();
        bus.bin_in = 6'd42;
        bus.start  = 1'b1;
        last_done  = -1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (bus.busy !== 1'b1 && t < 20) begin tick(); t++; end
            tick();
            tick();
            bus.bin_in = 6'($urandom);
            t = 0;
            while (bus.done !== 1'b1 && t < 20) begin tick(); t++; end
            chk("held_start_result", {bus.neg, bus.bcd_tens, bus.bcd_ones}, ref_conv(6'd42));
            if (last_done >= 0) chk("held_start_period", cyc - last_done, 8);
            last_done  = cyc;
            bus.bin_in = 6'd42;
        end
        bus.start = 1'b0;
        tick();

        // random start/operand traffic, including starts while busy
        for (int i = 0; i < 400; i++) begin
            bus.start  = ($urandom_range(0, 2) == 0);
            bus.bin_in = 6'($urandom);
            tick();
        end
        bus.start = 1'b0;

        // reset three cycles into a conversion
        convert(6'd63, res, lat);
        wait_ready();
        bus.start  = 1'b1;
        bus.bin_in = 6'd63;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", {bus.neg, bus.bcd_tens, bus.bcd_ones}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_convert_ctrl.md
BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (6-bit binary in, two 4-bit BCD digits out).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a conversion; sampled only while ready=1.
REQ-005 bin_in  input  6  binary operand; captured on the edge where start is accepted.
REQ-006 ready  output  1  high in IDLE only; start accepted this cycle.
REQ-007 busy  output  1  high while iterations are in progress.
REQ-008 done  output  1  one-cycle pulse; result valid from that cycle onward.
REQ-009 bcd_tens  output  4  tens digit, range 0..6.
REQ-010 bcd_ones  output  4  ones digit, range 0..9.
REQ-011 neg  output  1  sign of result (see Configuration); 0 when unsigned.

Function
REQ-012 Algorithm: shift-and-add-3 over a 14-bit working register {tens[3:0], ones[3:0], bin[5:0]}.
REQ-013 States: IDLE, SHIFT, DONE; encoding 2 bits.
REQ-014 IDLE: ready=1; on start=1, load {0,0,operand}, clear iteration counter, go to SHIFT.
REQ-015 SHIFT: each cycle, each digit >=5 gets +3 (values 5..9 map to 8..12; 0..4 unchanged), then whole register shifts left 1; counter increments.
REQ-016 SHIFT exits to DONE on the edge completing the 6th shift; counter 3 bits, no wrap beyond 6.
REQ-017 At that same edge bcd_tens/bcd_ones/neg registers update from the working register.
REQ-018 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-019 Latency: start accepted at edge k -> done high in cycle after edge k+6; next start accepted at edge k+8 earliest.
REQ-020 busy=1 in SHIFT only; ready=1 in IDLE only; both 0 in DONE.
REQ-021 start while busy or in DONE ignored; no queuing; bin_in changes during SHIFT have no effect.
REQ-022 Result outputs hold last completed value until next completion; never show intermediate values.
REQ-023 Adjusted digit values outside 0..9 before adjust are unreachable; no handling required.

Reset
REQ-024 rst_n=0 forces IDLE immediately: ready=1, busy=0, done=0, bcd_tens=0, bcd_ones=0, neg=0, counter=0, working register=0.
REQ-025 Reset during SHIFT aborts conversion; no done pulse; outputs return to 0.
REQ-026 First start accepted on first clk edge after rst_n deasserts with start=1.

Configuration
REQ-027 Macro BCD_CONV_SIGNED_EN defined: bin_in is two's complement (-32..31); magnitude loaded, neg=bin_in[5] latched at start; -32 -> neg=1, 3, 2.
REQ-028 Macro undefined: bin_in unsigned 0..63; neg tied 0; latency identical.

Structure
REQ-029 Shared package holds state enum (IDLE/SHIFT/DONE), ITER_COUNT=6, BIN_W=6, DIGIT_W=4.
REQ-030 One sub-module bcd_add3: 4-bit combinational add-3-if->=5 cell, instanced twice (tens, ones).

Verification
REQ-031 Unsigned: start, bin_in=63 -> done at k+7 cycle, tens=6, ones=3, neg=0.
REQ-032 Boundaries: bin_in=0 -> 0,0; 9 -> 0,9; 10 -> 1,0; exhaustive 0..63 vs reference model.
REQ-033 start held high continuously with bin_in=42 -> conversions every 8 cycles, each 4,2; mid-busy bin_in change ignored.
REQ-034 Reset asserted 3 cycles into SHIFT -> no done, all outputs 0, ready=1 asynchronously.
REQ-035 BCD_CONV_SIGNED_EN: bin_in=6'b100000 -> neg=1, 3,2; 6'b111111 -> neg=1, 0,1; 31 -> neg=0, 3,1.
